// File: rtl/alu_cmd_issuer_pkg.sv
// Package: alu_cmd_issuer_pkg
// Purpose: shared constants for the ALU_16B issue stage. Holds the ALU function
//   codes, flag bit positions, the issuer FSM state encoding and the command word
//   layout that is stored in the command FIFO.
// Ports: none (package).
package alu_cmd_issuer_pkg;

  localparam logic [3:0] FUN_ADD   = 4'b0000;
  localparam logic [3:0] FUN_SUB   = 4'b0001;
  localparam logic [3:0] FUN_MUL   = 4'b0010;
  localparam logic [3:0] FUN_DIV   = 4'b0011;
  localparam logic [3:0] FUN_AND   = 4'b0100;
  localparam logic [3:0] FUN_OR    = 4'b0101;
  localparam logic [3:0] FUN_NAND  = 4'b0110;
  localparam logic [3:0] FUN_NOR   = 4'b0111;
  localparam logic [3:0] FUN_XOR   = 4'b1000;
  localparam logic [3:0] FUN_XNOR  = 4'b1001;
  localparam logic [3:0] FUN_CMPEQ = 4'b1010;
  localparam logic [3:0] FUN_CMPG  = 4'b1011;
  localparam logic [3:0] FUN_CMPL  = 4'b1100;
  localparam logic [3:0] FUN_SHR   = 4'b1101;
  localparam logic [3:0] FUN_SHL   = 4'b1110;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ARITH = 1;
  localparam int FLAG_LOGIC = 2;
  localparam int FLAG_CMP   = 3;
  localparam int FLAG_SHIFT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Interface: alu_cmd_issuer_if
// Purpose: command and response valid/ready channels of the ALU issue stage.
// Signals:
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_fun  command channel (source -> issuer)
//   rsp_valid/rsp_ready/rsp_out/rsp_flags/rsp_err  response channel (issuer -> sink)
// Modports: master = command source / response sink, slave = the issuer.
interface alu_cmd_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_fun;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_out;
  logic [4:0]  rsp_flags;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_cmd_issuer_fifo.sv
// Module: alu_cmd_issuer_fifo
// Purpose: synchronous command FIFO, DEPTH entries of WIDTH bits. Full/empty are
//   derived from the pointer difference (occupancy count); pointers carry one
//   extra wrap bit. Push while full and pop while empty are ignored.
// Ports:
//   CLK, RST       clock, async active-low reset
//   i_push, i_data write request and data
//   i_pop, o_data  read request and head data (show-ahead)
//   o_full, o_empty occupancy status
module alu_cmd_issuer_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (w_count == (AW+1)'(DEPTH));
  assign o_empty   = (w_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// Module: alu_cmd_issuer
// Purpose: issue stage in front of ALU_16B. Queues commands, issues one at a
//   time on ALU_A/ALU_B/ALU_FUN, waits ALU_LAT edges, captures ALU_OUT/ALU_FLAGS
//   into a response register and hands it out over a valid/ready channel.
// Optional build macro: DIV0_TRAP_EN - a DIV with b==0 is answered locally
//   (rsp_out=0, Arith flag, rsp_err=1) without touching the ALU.
// Ports:
//   CLK, RST            clock, async active-low reset
//   bus (slave)         command and response channels
//   ALU_A/ALU_B/ALU_FUN registered operands/function to the ALU
//   ALU_OUT/ALU_FLAGS   ALU result and {Shift,CMP,Logic,Arith,Carry}
//   busy                FSM active or commands queued
//
// state   | meaning
// IDLE    | waiting for a queued command; pops and issues it
// EXEC    | ALU inputs held, latency counter running down
// CAPT    | ALU result valid; latched into response register at the edge
// RESP    | response offered, held until rsp_ready
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                CLK,
  input  logic                RST,
  alu_cmd_issuer_if.slave     bus,
  output logic [15:0]         ALU_A,
  output logic [15:0]         ALU_B,
  output logic [3:0]          ALU_FUN,
  input  logic [15:0]         ALU_OUT,
  input  logic [4:0]          ALU_FLAGS,
  output logic                busy
);
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

  state_t      r_state;
  state_t      w_next_state;
  cmd_t        w_cmd_in;
  cmd_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_trap;
  logic        w_pop;
  logic        w_issue;
  logic        w_trap_rsp;
  logic        w_capt;
  logic        w_rsp_done;
  logic [2:0]  r_lat_cnt;
  logic [15:0] r_alu_a;
  logic [15:0] r_alu_b;
  logic [3:0]  r_alu_fun;
  logic [15:0] r_rsp_out;
  logic [4:0]  r_rsp_flags;

  assign w_cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, fun: bus.cmd_fun};

  alu_cmd_issuer_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (bus.cmd_valid & bus.cmd_ready),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.cmd_ready = ~w_full;

`ifdef DIV0_TRAP_EN
  assign w_trap = (w_head.fun == FUN_DIV) && (w_head.b == 16'h0000);
`else
  assign w_trap = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty) w_next_state = w_trap ? ST_RESP : ST_EXEC;
      ST_EXEC: if (r_lat_cnt == 3'd0) w_next_state = ST_CAPT;
      ST_CAPT: w_next_state = ST_RESP;
      ST_RESP: if (w_rsp_done) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = 1'b0;
    w_issue    = 1'b0;
    w_trap_rsp = 1'b0;
    w_capt     = 1'b0;
    w_rsp_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pop      = ~w_empty;
        w_issue    = ~w_empty & ~w_trap;
        w_trap_rsp = ~w_empty & w_trap;
      end
      ST_CAPT: w_capt     = 1'b1;
      ST_RESP: w_rsp_done = bus.rsp_ready;
      default: ;
    endcase
  end

  // ALU inputs only change on issue, so they hold through EXEC/CAPT/RESP and IDLE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_lat_cnt <= '0;
    end else if (w_issue) begin
      r_alu_a   <= w_head.a;
      r_alu_b   <= w_head.b;
      r_alu_fun <= w_head.fun;
      r_lat_cnt <= LAT_INIT;
    end else if (r_state == ST_EXEC && r_lat_cnt != 3'd0) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rsp_out   <= '0;
      r_rsp_flags <= '0;
    end else if (w_capt) begin
      r_rsp_out   <= ALU_OUT;
      r_rsp_flags <= ALU_FLAGS;
    end else if (w_trap_rsp) begin
      r_rsp_out   <= '0;
      r_rsp_flags <= 5'(1 << FLAG_ARITH);
    end
  end

`ifdef DIV0_TRAP_EN
  logic r_rsp_err;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)            r_rsp_err <= 1'b0;
    else if (w_capt)     r_rsp_err <= 1'b0;
    else if (w_trap_rsp) r_rsp_err <= 1'b1;
  end
  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_out   = r_rsp_out;
  assign bus.rsp_flags = r_rsp_flags;
  assign ALU_A         = r_alu_a;
  assign ALU_B         = r_alu_b;
  assign ALU_FUN       = r_alu_fun;
  assign busy          = (r_state != ST_IDLE) | ~w_empty;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench: tb_alu_cmd_issuer
// Directed vectors against alu_cmd_issuer with a behavioural one-cycle ALU_16B
// model downstream. Expected values are hand-computed constants.
module tb_alu_cmd_issuer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_fun;
  logic [4:0]  alu_flags;
  logic        busy;
  int          n_checks = 0;
  int          n_errors = 0;

  alu_cmd_issuer_if bus();

  alu_cmd_issuer dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .ALU_A     (alu_a),
    .ALU_B     (alu_b),
    .ALU_FUN   (alu_fun),
    .ALU_OUT   (alu_out),
    .ALU_FLAGS (alu_flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ALU_16B stand-in: registered result, flags {Shift,CMP,Logic,Arith,Carry}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out   <= '0;
      alu_flags <= '0;
    end else begin
      alu_flags <= '0;
      case (alu_fun)
        4'h0: begin alu_out <= alu_a + alu_b; alu_flags <= {3'b000, 1'b1, ({1'b0, alu_a} + {1'b0, alu_b}) > 17'hffff}; end
        4'h1: begin alu_out <= alu_a - alu_b; alu_flags <= 5'b00010; end
        4'h2: begin alu_out <= alu_a * alu_b; alu_flags <= 5'b00010; end
        4'h3: begin alu_out <= (alu_b == 0) ? 16'h0 : alu_a / alu_b; alu_flags <= 5'b00010; end
        4'h4: begin alu_out <= alu_a & alu_b; alu_flags <= 5'b00100; end
        4'h5: begin alu_out <= alu_a | alu_b; alu_flags <= 5'b00100; end
        4'h6: begin alu_out <= ~(alu_a & alu_b); alu_flags <= 5'b00100; end
        4'h7: begin alu_out <= ~(alu_a | alu_b); alu_flags <= 5'b00100; end
        4'h8: begin alu_out <= alu_a ^ alu_b; alu_flags <= 5'b00100; end
        4'h9: begin alu_out <= ~(alu_a ^ alu_b); alu_flags <= 5'b00100; end
        4'ha: begin alu_out <= (alu_a == alu_b) ? 16'd1 : 16'd0; alu_flags <= 5'b01000; end
        4'hb: begin alu_out <= (alu_a > alu_b) ? 16'd2 : 16'd0; alu_flags <= 5'b01000; end
        4'hc: begin alu_out <= (alu_a < alu_b) ? 16'd3 : 16'd0; alu_flags <= 5'b01000; end
        4'hd: begin alu_out <= alu_a >> 1; alu_flags <= 5'b10000; end
        4'he: begin alu_out <= alu_a << 1; alu_flags <= 5'b10000; end
        default: alu_out <= '0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
    int n = 0;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_fun = fun; bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic ok);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    ok = bus.rsp_valid;
  endtask

  // Expects rsp_ready=1 so the response is consumed at the following edge.
  task automatic get_rsp(input string tag, input logic [15:0] e_out, input logic [4:0] e_flags, input logic e_err);
    logic ok;
    wait_rsp(ok);
    if (!ok) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_out"},   32'(bus.rsp_out),   32'(e_out));
    check({tag, "_flags"}, 32'(bus.rsp_flags), 32'(e_flags));
    check({tag, "_err"},   32'(bus.rsp_err),   32'(e_err));
    @(negedge clk);
  endtask

  initial begin
    int   n;
    logic seen;
    logic ok;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_fun = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_out",   32'(bus.rsp_out),   32'd0);
    check("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_alu_a",     32'(alu_a),         32'd0);
    check("rst_alu_fun",   32'(alu_fun),       32'd0);

    // 1: reset while the second command is in EXEC with three more queued
    push(16'd1, 16'd1, 4'h0);
    push(16'd2, 16'd2, 4'h0);
    push(16'd3, 16'd3, 4'h0);
    push(16'd4, 16'd4, 4'h0);
    push(16'd5, 16'd5, 4'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("t1_exec_alu_a", 32'(alu_a), 32'd2);
    check("t1_exec_busy",  32'(busy),  32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("t1_busy",      32'(busy),          32'd0);
    check("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("t1_alu_a",     32'(alu_a),         32'd0);
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); seen |= bus.rsp_valid; end
    check("t1_no_rsp", 32'(seen), 32'd0);

    // 2: single ADD, latency from push edge and result
    push(16'd6, 16'd7, 4'h0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("t2_latency", 32'(n), 32'd3);
    check("t2_out",     32'(bus.rsp_out),   32'd13);
    check("t2_flags",   32'(bus.rsp_flags), 32'b00010);
    @(negedge clk);
    check("t2_consumed", 32'(bus.rsp_valid), 32'd0);
    check("t2_idle",     32'(busy),          32'd0);

    // 3 + 6: fill the FIFO behind a stalled response; a held push lands after the pop
    bus.rsp_ready = 1'b0;
    push(16'd15, 16'd4, 4'h1);
    push(16'd4, 16'd3, 4'h2);
    push(16'd9, 16'd3, 4'h3);
    push(16'haaaa, 16'h5555, 4'h4);
    push(16'haaaa, 16'h5555, 4'h5);
    check("t3_full_ready", 32'(bus.cmd_ready), 32'd0);
    check("t3_full_busy",  32'(busy),          32'd1);
    fork
      push(16'h00ff, 16'h0f0f, 4'h8);
      begin
        repeat (3) @(negedge clk);
        check("t6_held_ready", 32'(bus.cmd_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        get_rsp("t3_sub", 16'd11,    5'b00010, 1'b0);
        get_rsp("t3_mul", 16'd12,    5'b00010, 1'b0);
        get_rsp("t3_div", 16'd3,     5'b00010, 1'b0);
        get_rsp("t3_and", 16'h0000,  5'b00100, 1'b0);
        get_rsp("t3_or",  16'hffff,  5'b00100, 1'b0);
        get_rsp("t6_xor", 16'h0ff0,  5'b00100, 1'b0);
      end
    join
    @(negedge clk);
    check("t3_drained", 32'(busy), 32'd0);

    // 4: stalled CMPG response stays stable
    bus.rsp_ready = 1'b0;
    push(16'h000f, 16'h000a, 4'hb);
    wait_rsp(ok);
    check("t4_rsp_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_out",     32'(bus.rsp_out),   32'd2);
      check("t4_flags",   32'(bus.rsp_flags), 32'b01000);
      check("t4_valid",   32'(bus.rsp_valid), 32'd1);
      check("t4_alu",     {alu_a, alu_b[11:0], alu_fun}, {16'h000f, 12'h00a, 4'hb});
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_released", 32'(bus.rsp_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); seen |= bus.rsp_valid; end
    check("t4_single_rsp", 32'(seen), 32'd0);

    // 5: divide by zero
    push(16'd14, 16'd0, 4'h3);
`ifdef DIV0_TRAP_EN
    get_rsp("t5_trap", 16'd0, 5'b00010, 1'b1);
    check("t5_alu_fun", 32'(alu_fun), 32'hb);
`else
    get_rsp("t5_div0", 16'd0, 5'b00010, 1'b0);
    check("t5_alu_fun", 32'(alu_fun), 32'h3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
